// File: rtl/shift_seq_pkg.sv
// Shared definitions for the cpu32e2 shifters: op encodings, sequential-shifter
// state enum, and small op-classification helpers.
package shifterPkg;

    typedef enum logic [2:0] {
        SHL = 3'd0,
        SHR = 3'd1,
        SAR = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4,
        RCL = 3'd5,
        RCR = 3'd6
    } shiftOpSel;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } shiftSeqState;

    localparam int SHIFT_SEQ_FAST_STEP = 4;

    function automatic logic op_is_valid(input shiftOpSel op);
        case (op)
            SHL, SHR, SAR, ROL, ROR, RCL, RCR: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // Left-moving ops take overflow from carry vs. MSB; right-moving from the top two bits.
    function automatic logic op_is_left(input shiftOpSel op);
        case (op)
            SHL, ROL, RCL: return 1'b1;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/shift_seq_step.sv
// Combinational step for the sequential shifter: one 1-bit shift/rotate step,
// or four chained 1-bit steps when step4 is set.
module shift_seq_step
    import shifterPkg::*;
(
    input  shiftOpSel   op,
    input  logic        carry_in,
    input  logic [31:0] data_in,
    input  logic        step4,
    output logic        carry_out,
    output logic [31:0] data_out
);

    logic        step_c;
    logic [31:0] step_d;

    // Returns {carry, data} after a single-bit step; unknown ops pass through.
    function automatic logic [32:0] step_one(input shiftOpSel o, input logic c, input logic [31:0] d);
        case (o)
            SHL:     return {d[31], d[30:0], 1'b0};
            SHR:     return {d[0], 1'b0, d[31:1]};
            SAR:     return {d[0], d[31], d[31:1]};
            ROL:     return {d[31], d[30:0], d[31]};
            ROR:     return {d[0], d[0], d[31:1]};
            RCL:     return {d[31], d[30:0], c};
            RCR:     return {d[0], c, d[31:1]};
            default: return {c, d};
        endcase
    endfunction

    always_comb begin
        step_c = carry_in;
        step_d = data_in;
        for (int i = 0; i < SHIFT_SEQ_FAST_STEP; i++) begin
            if (i == 0 || step4) begin
                {step_c, step_d} = step_one(op, step_c, step_d);
            end
        end
        carry_out = step_c;
        data_out  = step_d;
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate unit iterating over the shift count with valid/ready
// handshakes. Define SHIFT_SEQ_FAST_EN to take 4-bit steps while >=4 bits remain.
module shift_seq
    import shifterPkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  shiftOpSel   shiftOp,
    input  logic [4:0]  count,
    input  logic        carryIn,
    input  logic [31:0] dataIn,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        carryOut,
    output logic        overflowOut,
    output logic [31:0] dataOut
);

    shiftSeqState state_q, state_d;
    shiftOpSel    op_q, op_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         carry_q, carry_d;
    logic [31:0]  data_q, data_d;
    logic         bypass_q, bypass_d;

    logic         use_fast;
    logic [4:0]   step_len;
    logic         step_carry;
    logic [31:0]  step_data;

`ifdef SHIFT_SEQ_FAST_EN
    assign use_fast = (cnt_q >= 5'(SHIFT_SEQ_FAST_STEP));
`else
    assign use_fast = 1'b0;
`endif
    assign step_len = use_fast ? 5'(SHIFT_SEQ_FAST_STEP) : 5'd1;

    shift_seq_step u_step (
        .op        (op_q),
        .carry_in  (carry_q),
        .data_in   (data_q),
        .step4     (use_fast),
        .carry_out (step_carry),
        .data_out  (step_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= SHL;
            cnt_q    <= 5'd0;
            carry_q  <= 1'b0;
            data_q   <= 32'd0;
            bypass_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            data_q   <= data_d;
            bypass_q <= bypass_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        data_d       = data_q;
        bypass_d     = bypass_q;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    op_d     = shiftOp;
                    cnt_d    = count;
                    carry_d  = carryIn;
                    data_d   = dataIn;
                    // Zero counts and unknown ops skip RUN and report overflow 0.
                    bypass_d = (count == 5'd0) || !op_is_valid(shiftOp);
                    state_d  = bypass_d ? DONE : RUN;
                end
            end
            RUN: begin
                carry_d = step_carry;
                data_d  = step_data;
                cnt_d   = cnt_q - step_len;
                if (cnt_d == 5'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        overflowOut = 1'b0;
        if (!bypass_q) begin
            overflowOut = op_is_left(op_q) ? (carry_q ^ data_q[31]) : (data_q[31] ^ data_q[30]);
        end
    end

    assign carryOut = carry_q;
    assign dataOut  = data_q;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: the driver pushes hand-computed results, the
// monitor pops and checks them (plus latency and hold stability) as results appear.
module tb_shift_seq;
    import shifterPkg::*;

    typedef struct {
        logic [31:0] d;
        logic        c;
        logic        o;
        int          lat;
        int          hold;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    shiftOpSel   shiftOp = SHL;
    logic [4:0]  count = 5'd0;
    logic        carryIn = 1'b0;
    logic [31:0] dataIn = 32'd0;
    logic        result_valid;
    logic        result_ready = 1'b1;
    logic        carryOut;
    logic        overflowOut;
    logic [31:0] dataOut;

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t sb[$];

    shift_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .shiftOp      (shiftOp),
        .count        (count),
        .carryIn      (carryIn),
        .dataIn       (dataIn),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .carryOut     (carryOut),
        .overflowOut  (overflowOut),
        .dataOut      (dataOut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int expLatency(input shiftOpSel op, input logic [4:0] cnt);
        if (cnt == 5'd0 || op > RCR) return 1;
`ifdef SHIFT_SEQ_FAST_EN
        return int'(cnt) / 4 + int'(cnt) % 4 + 1;
`else
        return int'(cnt) + 1;
`endif
    endfunction

    task automatic applyStimulus(input shiftOpSel op, input logic [4:0] cnt, input logic cin,
                                 input logic [31:0] din, input logic [31:0] ed, input logic ec,
                                 input logic eo, input int hold, input bit push);
        int   waitCnt = 0;
        exp_t e;
        @(negedge clk);
        shiftOp     = op;
        count       = cnt;
        carryIn     = cin;
        dataIn      = din;
        start_valid = 1'b1;
        while (!start_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!start_ready) begin
            checks++;
            fails++;
            $display("[TB] FAIL accept timeout: start_ready stayed 0");
            start_valid = 1'b0;
            return;
        end
        if (push) begin
            e.d    = ed;
            e.c    = ec;
            e.o    = eo;
            e.lat  = expLatency(op, cnt);
            e.hold = hold;
            e.acc  = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    // Monitor: pops an expectation on each result_valid rise and checks hold stability.
    initial begin
        bit          prevValid = 1'b0;
        bit          postHs = 1'b0;
        int          holdLeft = 0;
        exp_t        e;
        logic [31:0] capD;
        logic        capC, capO;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevValid = 1'b0;
                postHs    = 1'b0;
                continue;
            end
            if (postHs) begin
                checkOutput("start_ready after handshake", {31'd0, start_ready}, 32'd1);
                checkOutput("result_valid after handshake", {31'd0, result_valid}, 32'd0);
                postHs = 1'b0;
            end
            if (result_valid && !prevValid) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected result: dataOut 0x%08h with empty scoreboard", dataOut);
                    holdLeft = 0;
                end else begin
                    e = sb.pop_front();
                    checkOutput("dataOut", dataOut, e.d);
                    checkOutput("carryOut", {31'd0, carryOut}, {31'd0, e.c});
                    checkOutput("overflowOut", {31'd0, overflowOut}, {31'd0, e.o});
                    checkOutput("latency", cyc - e.acc + 1, e.lat);
                    holdLeft = e.hold;
                end
                capD = dataOut;
                capC = carryOut;
                capO = overflowOut;
                result_ready = (holdLeft == 0);
            end else if (result_valid) begin
                checkOutput("held dataOut", dataOut, capD);
                checkOutput("held flags", {30'd0, carryOut, overflowOut}, {30'd0, capC, capO});
                if (holdLeft > 0) holdLeft--;
                if (holdLeft == 0) result_ready = 1'b1;
            end
            if (result_valid && result_ready) postHs = 1'b1;
            prevValid = result_valid;
        end
    end

    initial begin
        int waitCnt;
        int sawValid;
        $display("[TB] shift_seq scoreboard bench");

        repeat (2) @(negedge clk);
        checkOutput("reset start_ready", {31'd0, start_ready}, 32'd1);
        checkOutput("reset result_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("reset dataOut", dataOut, 32'd0);
        checkOutput("reset flags", {30'd0, carryOut, overflowOut}, 32'd0);
        reset = 1'b0;

        applyStimulus(SHL, 5'd1,  1'b0, 32'h8000_0001, 32'h0000_0002, 1'b1, 1'b1, 0, 1);
        applyStimulus(SAR, 5'd4,  1'b0, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0, 0, 1);
        applyStimulus(RCL, 5'd1,  1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 0, 1);
        applyStimulus(RCR, 5'd1,  1'b0, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 0, 1);
        applyStimulus(ROR, 5'd0,  1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 0, 1);
        applyStimulus(ROR, 5'd31, 1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 0, 1);
        applyStimulus(SHR, 5'd5,  1'b0, 32'hF000_0000, 32'h0780_0000, 1'b0, 1'b0, 0, 1);
        applyStimulus(SHR, 5'd1,  1'b0, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b1, 0, 1);
        applyStimulus(ROL, 5'd1,  1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 0, 1);
        applyStimulus(RCL, 5'd2,  1'b1, 32'h4000_0000, 32'h0000_0002, 1'b1, 1'b1, 0, 1);
        applyStimulus(RCR, 5'd5,  1'b1, 32'h0000_0010, 32'h0800_0000, 1'b1, 1'b0, 0, 1);
        applyStimulus(shiftOpSel'(3'd7), 5'd5, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, 0, 1);

        // Back-pressure: result held 3 cycles while a new request is pulsed.
        applyStimulus(SHL, 5'd2, 1'b0, 32'h0000_0003, 32'h0000_000C, 1'b0, 1'b0, 3, 1);
        waitCnt = 0;
        while (!result_valid && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("back-pressure result_valid", {31'd0, result_valid}, 32'd1);
        shiftOp     = ROL;
        count       = 5'd3;
        dataIn      = 32'hAAAA_5555;
        start_valid = 1'b1;
        @(negedge clk);
        checkOutput("start_ready in DONE", {31'd0, start_ready}, 32'd0);
        start_valid = 1'b0;

        // Abort SHL count=10 with reset in its third RUN cycle.
        applyStimulus(SHL, 5'd10, 1'b0, 32'h0000_FFFF, 32'd0, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort result_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("abort dataOut", dataOut, 32'd0);
        checkOutput("abort flags", {30'd0, carryOut, overflowOut}, 32'd0);
        checkOutput("abort start_ready", {31'd0, start_ready}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle after reset release", {31'd0, start_ready}, 32'd1);
        sawValid = 0;
        repeat (15) begin
            @(negedge clk);
            if (result_valid) sawValid++;
        end
        checkOutput("no result after abort", sawValid, 0);

        applyStimulus(SHL, 5'd10, 1'b0, 32'h0000_0001, 32'h0000_0400, 1'b0, 1'b0, 0, 1);

        waitCnt = 0;
        while ((sb.size() != 0 || result_valid) && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL drain timeout: %0d results never appeared", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
